// File: rtl/aes_pkg.sv
// Shared widths, scheduler enums and the AES byte-substitution arithmetic.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KS_RUN = 2'd2
  } sched_state_t;

  typedef enum logic {
    GR_ST = 1'b0,
    GR_KS = 1'b1
  } grant_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] dout
);

  assign dout = sbox_calc(addr);

endmodule

// File: rtl/aes_subbytes_sched.sv
// Shares NUM_SBOX S-box lanes between state SubBytes and key-schedule SubWord,
// processing each request in NUM_SBOX-byte chunks, one chunk per cycle.
module aes_subbytes_sched
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_req_valid,
  output logic                   st_req_ready,
  input  logic [AES_STATE_W-1:0] st_in,
  output logic                   st_out_valid,
  output logic [AES_STATE_W-1:0] st_out,
  input  logic                   ks_req_valid,
  output logic                   ks_req_ready,
  input  logic [AES_WORD_W-1:0]  ks_in,
  output logic                   ks_out_valid,
  output logic [AES_WORD_W-1:0]  ks_out,
  output logic                   busy
);

  localparam int unsigned C_ST  = 16 / NUM_SBOX;
  localparam int unsigned C_KS  = 4 / NUM_SBOX;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 4;

  sched_state_t            state;
  sched_state_t            state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  grant_t                  last_grant;
  grant_t                  grant_nxt;
  logic                    st_take;
  logic                    ks_take;
  logic                    st_done;
  logic                    ks_done;
  logic [AES_STATE_W-1:0]  operand;
  logic [IDX_W-1:0]        byte_idx  [NUM_SBOX];
  logic [AES_BYTE_W-1:0]   lane_addr [NUM_SBOX];
  logic [AES_BYTE_W-1:0]   lane_dout [NUM_SBOX];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GR_ST;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= grant_nxt;
    end
  end

  // Next state, round-robin grant and chunk counting
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    grant_nxt    = last_grant;
    st_req_ready = 1'b0;
    ks_req_ready = 1'b0;
    st_take      = 1'b0;
    ks_take      = 1'b0;
    st_done      = 1'b0;
    ks_done      = 1'b0;
    case (state)
      IDLE: begin
        if (st_req_valid && ks_req_valid) begin
          if (last_grant == GR_ST) ks_req_ready = 1'b1;
          else                     st_req_ready = 1'b1;
        end else begin
          st_req_ready = st_req_valid;
          ks_req_ready = ks_req_valid;
        end
        st_take = st_req_valid && st_req_ready;
        ks_take = ks_req_valid && ks_req_ready;
        if (st_take) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          grant_nxt = GR_ST;
        end else if (ks_take) begin
          state_nxt = KS_RUN;
          cnt_nxt   = '0;
          grant_nxt = GR_KS;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(C_ST - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          st_done   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      KS_RUN: begin
        if (cnt == CNT_W'(C_KS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ks_done   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane j serves operand byte cnt*NUM_SBOX+j; lanes are parked at zero while idle
  always_comb begin
    for (int unsigned j = 0; j < NUM_SBOX; j++) begin
      byte_idx[j]  = IDX_W'(32'(cnt) * NUM_SBOX + j);
      lane_addr[j] = (state == IDLE) ? 8'h00 : operand[{byte_idx[j], 3'b000} +: AES_BYTE_W];
    end
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    aes_sbox u_sbox (
      .addr (lane_addr[j]),
      .dout (lane_dout[j])
    );
  end

  // Operand capture, in-place write-back and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      operand      <= '0;
      st_out       <= '0;
      ks_out       <= '0;
      st_out_valid <= 1'b0;
      ks_out_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      st_out_valid <= st_done;
      ks_out_valid <= ks_done;
      busy         <= (state_nxt != IDLE);
      if (st_take) begin
        operand <= st_in;
      end else if (ks_take) begin
        operand <= {{(AES_STATE_W - AES_WORD_W){1'b0}}, ks_in};
      end
      if (state == ST_RUN) begin
        for (int unsigned j = 0; j < NUM_SBOX; j++) begin
          st_out[{byte_idx[j], 3'b000} +: AES_BYTE_W] <= lane_dout[j];
        end
      end
      if (state == KS_RUN) begin
        for (int unsigned j = 0; j < NUM_SBOX; j++) begin
          ks_out[{byte_idx[j][1:0], 3'b000} +: AES_BYTE_W] <= lane_dout[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_subbytes_sched.sv
// Bench for aes_subbytes_sched: NUM_SBOX = 4, 2 and 1 run side by side, each against
// a transaction-level model (field-built S-box table, cycle-stamped arbitration/latency).
module tb_aes_subbytes_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [3];
  logic [7:0] sbt [256];

  typedef struct {
    bit           ks;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int r, aa, bb;
    r = 0; aa = int'(a); bb = int'(b);
    while (bb != 0) begin
      if ((bb & 1) != 0) r = r ^ aa;
      aa = aa << 1;
      if ((aa & 256) != 0) aa = aa ^ 283;
      bb = bb >> 1;
    end
    return 8'(r);
  endfunction

  // S-box table: inverse found by search, then the affine transform
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      sbt[x] = s;
    end
  end

  function automatic logic [127:0] sub_bytes(input logic [127:0] d, input int nbytes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = sbt[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned N = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    localparam int C_ST = 16 / N;
    localparam int C_KS = 4 / N;

    logic         rst, stv, st_rdy, st_ov, ksv, ks_rdy, ks_ov, busy;
    logic [127:0] st_in, st_out;
    logic [31:0]  ks_in, ks_out;
    bit           lg_ks;
    vec_t         vt [4];

    aes_subbytes_sched #(.NUM_SBOX(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .st_req_valid (stv),
      .st_req_ready (st_rdy),
      .st_in        (st_in),
      .st_out_valid (st_ov),
      .st_out       (st_out),
      .ks_req_valid (ksv),
      .ks_req_ready (ks_rdy),
      .ks_in        (ks_in),
      .ks_out_valid (ks_ov),
      .ks_out       (ks_out),
      .busy         (busy)
    );

    task automatic ck(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chk($sformatf("N%0d %s", N, nm), act, exp);
    endtask

    task automatic reset_dut();
      rst = 1'b1; stv = 1'b0; ksv = 1'b0; st_in = '0; ks_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      lg_ks = 1'b0;
    endtask

    // One isolated request; returns result and cycles from handshake cycle to pulse
    task automatic single(input bit ks, input logic [127:0] din,
                          output logic [127:0] dout, output int lat);
      int w;
      lat = -1; dout = '0; w = 0;
      @(negedge clk);
      if (ks) begin ksv = 1'b1; ks_in = din[31:0]; end
      else    begin stv = 1'b1; st_in = din; end
      #1;
      while (!(ks ? ks_rdy : st_rdy) && w < 50) begin
        @(negedge clk); #1; w++;
      end
      if (w >= 50) begin
        ck("handshake timeout", 128'(w), 128'(0));
        stv = 1'b0; ksv = 1'b0;
        return;
      end
      lg_ks = ks;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 1) begin
          stv = 1'b0; ksv = 1'b0; st_in = ~st_in; ks_in = ~ks_in;
        end
        if (ks ? ks_ov : st_ov) begin
          lat = k;
          dout = ks ? {96'b0, ks_out} : st_out;
          break;
        end
      end
      if (lat > 0) begin
        @(negedge clk);
        ck("out_valid single pulse", 128'(ks ? ks_ov : st_ov), 128'(0));
      end
    endtask

    // Randomised/held traffic checked cycle by cycle against a grant/latency model
    task automatic engine(input int p_st, input int p_ks, input int n_stop, input int max_cyc);
      int cyc, nfree, st_done, ks_done, nreq;
      bit drop_st, drop_ks, es, ek, fin;
      logic [127:0] exp_st;
      logic [31:0]  exp_ks;
      cyc = 0; nfree = 0; st_done = -1; ks_done = -1; nreq = 0;
      drop_st = 0; drop_ks = 0; fin = 0; exp_st = '0; exp_ks = '0;
      stv = 1'b0; ksv = 1'b0;
      while (!fin && cyc < max_cyc) begin
        @(negedge clk);
        cyc++;
        ck("st_out_valid", 128'(st_ov), 128'(cyc == st_done));
        if (st_ov) ck("st_out", st_out, exp_st);
        ck("ks_out_valid", 128'(ks_ov), 128'(cyc == ks_done));
        if (ks_ov) ck("ks_out", 128'(ks_out), 128'(exp_ks));
        ck("busy", 128'(busy), 128'(cyc < nfree));
        if (drop_st) begin stv = 1'b0; drop_st = 0; end
        if (drop_ks) begin ksv = 1'b0; drop_ks = 0; end
        if (nreq < n_stop) begin
          if (!stv && int'($urandom_range(99)) < p_st) begin
            stv = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
          end
          if (!ksv && int'($urandom_range(99)) < p_ks) begin
            ksv = 1'b1; ks_in = $urandom;
          end
        end else if (!stv && !ksv && cyc > nfree) begin
          fin = 1;
        end
        #1;
        es = (cyc >= nfree) && stv && (!ksv || lg_ks);
        ek = (cyc >= nfree) && ksv && (!stv || !lg_ks);
        ck("st_req_ready", 128'(st_rdy), 128'(es));
        ck("ks_req_ready", 128'(ks_rdy), 128'(ek));
        if (stv && st_rdy) begin
          exp_st = sub_bytes(st_in, 16);
          st_done = cyc + C_ST + 1; nfree = st_done;
          lg_ks = 0; drop_st = 1; nreq++;
        end else if (ksv && ks_rdy) begin
          exp_ks = 32'(sub_bytes({96'b0, ks_in}, 4));
          ks_done = cyc + C_KS + 1; nfree = ks_done;
          lg_ks = 1; drop_ks = 1; nreq++;
        end
      end
      ck("traffic completed in budget", 128'(fin), 128'(1));
      stv = 1'b0; ksv = 1'b0;
    endtask

    initial begin
      logic [127:0] o, d;
      int lat, nov;
      reset_dut();
      ck("reset st_out", st_out, 128'(0));
      ck("reset ks_out", 128'(ks_out), 128'(0));
      ck("reset st_out_valid", 128'(st_ov), 128'(0));
      ck("reset ks_out_valid", 128'(ks_ov), 128'(0));
      ck("reset busy", 128'(busy), 128'(0));
      ck("reset st_req_ready", 128'(st_rdy), 128'(0));
      ck("reset ks_req_ready", 128'(ks_rdy), 128'(0));

      vt[0] = '{1'b1, 128'h09cf4f3c, 128'h018a84eb};
      vt[1] = '{1'b0, 128'h00102030405060708090a0b0c0d0e0f0,
                      128'h63cab7040953d051cd60e0e7ba70e18c};
      vt[2] = '{1'b0, 128'h0, {16{8'h63}}};
      vt[3] = '{1'b1, 128'hffffffff, 128'h16161616};
      for (int i = 0; i < 4; i++) begin
        single(vt[i].ks, vt[i].din, o, lat);
        ck($sformatf("vector %0d data", i), o, vt[i].dout);
        ck($sformatf("vector %0d latency", i), 128'(lat), 128'(vt[i].ks ? C_KS + 1 : C_ST + 1));
      end

      // Both requesters held valid: strict alternation starting with KS
      reset_dut();
      engine(100, 100, 20, 3000);
      // ST held valid: back-to-back acceptance in the pulse cycle
      engine(100, 0, 5, 1000);

      // Reset in the third ST_RUN cycle aborts the request
      @(negedge clk);
      stv = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      ck("abort request ready", 128'(st_rdy), 128'(1));
      @(negedge clk); stv = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; lg_ks = 0;
      ck("abort busy", 128'(busy), 128'(0));
      ck("abort st_out", st_out, 128'(0));
      ck("abort ks_out", 128'(ks_out), 128'(0));
      nov = 0;
      for (int k = 0; k < 25; k++) begin
        if (st_ov || ks_ov) nov++;
        @(negedge clk);
      end
      ck("abort no out_valid", 128'(nov), 128'(0));
      single(1'b0, vt[1].din, o, lat);
      ck("after abort data", o, vt[1].dout);
      ck("after abort latency", 128'(lat), 128'(C_ST + 1));

      // Every byte value through every lane position
      for (int r = 0; r < 16; r++) begin
        for (int s = 0; s < 4; s++) begin
          for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * r + ((i + s) % 16));
          single(1'b0, d, o, lat);
          ck($sformatf("byte sweep r%0d s%0d", r, s), o, sub_bytes(d, 16));
        end
      end

      engine(30, 30, 40, 4000);
      done[g] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      errors++;
      $display("FAIL run timeout: done flags %b%b%b expected 111", done[2], done[1], done[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
